bnn_conv_mix: RTL and testbench

Binary-weight 5×5 convolution followed by a 2×2 max-pool, used for both conv layers of the BNN inference path. Each run loads one 25-bit binarised kernel, requests a streamed single-channel image one signed 32-bit pixel per clock, and emits the pooled feature map in raster order. Mode 0 takes a 28×28 input to a 24×24 convolution and a 12×12 pooled output (144 values). Mode 1 takes a 12×12 input to an 8×8 convolution and a 4×4 pooled output (16 values).

---
 rtl/bnn_conv_mix.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_bnn_conv_mix.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_conv_mix.sv
// Binary-weight 5x5 convolution followed by 2x2 signed max-pool over a streamed
// single-channel image (28x28 or 12x12), one signed 32-bit pixel per clock.
module bnn_conv_mix (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               weight_en,
  input  logic               weight,
  input  logic signed [31:0] din,
  input  logic               state,
  output logic               din_ready,
  output logic               ovalid,
  output logic               done,
  output logic signed [31:0] dout
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_FIN    = 3'd4
  } fsm_t;

  fsm_t               fsm_q, fsm_d;
  logic               mode_q, mode_d;
  logic [24:0]        kernel_q, kernel_d;
  logic [9:0]         req_cnt_q, req_cnt_d;
  logic               din_ready_q, din_ready_d;
  logic               pix_en_q, pix_en_d;
  logic [4:0]         col_q, col_d, row_q, row_d;
  logic signed [31:0] lbuf_q [4][28];
  logic signed [31:0] lbuf_d [4][28];
  logic signed [31:0] win_q [5][5];
  logic signed [31:0] win_d [5][5];
  logic               win_vld_q, win_vld_d;
  logic [4:0]         wi_q, wi_d, wj_q, wj_d;
  logic signed [31:0] conv_q, conv_d;
  logic               conv_vld_q, conv_vld_d;
  logic [4:0]         ci_q, ci_d, cj_q, cj_d;
  logic signed [31:0] hprev_q, hprev_d;
  logic signed [31:0] hbuf_q [12];
  logic signed [31:0] hbuf_d [12];
  logic               ovalid_q, ovalid_d;
  logic               done_q, done_d;
  logic signed [31:0] dout_q, dout_d;

  logic [4:0]         wdim_s;
  logic [4:0]         last_s;
  logic [9:0]         npix_s;
  logic signed [31:0] acc_s;
  logic signed [31:0] hmax_s;

  function automatic logic signed [31:0] smax(input logic signed [31:0] a,
                                               input logic signed [31:0] b);
    return (a > b) ? a : b;
  endfunction

  // Next-state logic: pixel window, convolution, pooling and the run FSM.
  always_comb begin
    fsm_d       = fsm_q;
    mode_d      = mode_q;
    kernel_d    = kernel_q;
    req_cnt_d   = req_cnt_q;
    din_ready_d = din_ready_q;
    pix_en_d    = din_ready_q;
    col_d       = col_q;
    row_d       = row_q;
    lbuf_d      = lbuf_q;
    win_d       = win_q;
    win_vld_d   = 1'b0;
    wi_d        = wi_q;
    wj_d        = wj_q;
    conv_vld_d  = win_vld_q;
    ci_d        = wi_q;
    cj_d        = wj_q;
    hprev_d     = hprev_q;
    hbuf_d      = hbuf_q;
    ovalid_d    = 1'b0;
    done_d      = 1'b0;
    dout_d      = dout_q;
    hmax_s      = 32'sd0;
    wdim_s      = mode_q ? 5'd12 : 5'd28;
    npix_s      = mode_q ? 10'd144 : 10'd784;
    last_s      = wdim_s - 5'd5;

    // A pixel arrives one edge after its request; column comes from line buffers.
    if (pix_en_q) begin
      for (int rr = 0; rr < 5; rr++) begin
        for (int cc = 0; cc < 4; cc++) begin
          win_d[rr][cc] = win_q[rr][cc+1];
        end
      end
      for (int rr = 0; rr < 4; rr++) begin
        win_d[rr][4] = lbuf_q[3-rr][col_q];
      end
      win_d[4][4] = din;
      lbuf_d[0][col_q] = din;
      for (int k = 1; k < 4; k++) begin
        lbuf_d[k][col_q] = lbuf_q[k-1][col_q];
      end
      win_vld_d = (row_q >= 5'd4) && (col_q >= 5'd4);
      wi_d      = row_q - 5'd4;
      wj_d      = col_q - 5'd4;
      if (col_q == wdim_s - 5'd1) begin
        col_d = 5'd0;
        row_d = row_q + 5'd1;
      end else begin
        col_d = col_q + 5'd1;
      end
    end else begin
      win_vld_d = 1'b0;
    end

    acc_s = 32'sd0;
    for (int rr = 0; rr < 5; rr++) begin
      for (int cc = 0; cc < 5; cc++) begin
        if (kernel_q[24 - (5*rr + cc)]) begin
          acc_s = acc_s + win_q[rr][cc];
        end else begin
          acc_s = acc_s - win_q[rr][cc];
        end
      end
    end
    conv_d = acc_s;

    // Even conv rows park the horizontal pair max; odd rows finish the 2x2 pool.
    if (conv_vld_q) begin
      if (!cj_q[0]) begin
        hprev_d = conv_q;
      end else begin
        hmax_s = smax(hprev_q, conv_q);
        if (!ci_q[0]) begin
          hbuf_d[cj_q[4:1]] = hmax_s;
        end else begin
          dout_d   = smax(hbuf_q[cj_q[4:1]], hmax_s);
          ovalid_d = 1'b1;
          done_d   = (ci_q == last_s) && (cj_q == last_s);
        end
      end
    end else begin
      hprev_d = hprev_q;
    end

    case (fsm_q)
      S_IDLE: begin
        if (weight_en) begin
          kernel_d = {kernel_q[23:0], weight};
        end else begin
          kernel_d = kernel_q;
        end
        if (start) begin
          mode_d    = state;
          req_cnt_d = 10'd0;
          row_d     = 5'd0;
          col_d     = 5'd0;
          if (weight_en) begin
            fsm_d = S_LOAD;
          end else begin
            fsm_d       = S_STREAM;
            din_ready_d = 1'b1;
          end
        end else begin
          fsm_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (!start) begin
          fsm_d = S_IDLE;
        end else if (weight_en) begin
          kernel_d = {kernel_q[23:0], weight};
        end else begin
          fsm_d       = S_STREAM;
          din_ready_d = 1'b1;
        end
      end
      S_STREAM: begin
        if (!start) begin
          fsm_d = S_IDLE;
        end else if (din_ready_q) begin
          req_cnt_d = req_cnt_q + 10'd1;
          if (req_cnt_q == npix_s - 10'd1) begin
            din_ready_d = 1'b0;
            fsm_d       = S_DRAIN;
          end else begin
            din_ready_d = 1'b1;
          end
        end else begin
          fsm_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!start) begin
          fsm_d = S_IDLE;
        end else if (done_d) begin
          fsm_d = S_FIN;
        end else begin
          fsm_d = S_DRAIN;
        end
      end
      S_FIN: begin
        if (!start) begin
          fsm_d = S_IDLE;
        end else begin
          fsm_d = S_FIN;
        end
      end
      default: begin
        fsm_d = S_IDLE;
      end
    endcase

    // Abort drops the whole pipeline but keeps the kernel for a later run.
    if (!start && (fsm_q == S_LOAD || fsm_q == S_STREAM || fsm_q == S_DRAIN)) begin
      din_ready_d = 1'b0;
      pix_en_d    = 1'b0;
      win_vld_d   = 1'b0;
      conv_vld_d  = 1'b0;
      ovalid_d    = 1'b0;
      done_d      = 1'b0;
      dout_d      = 32'sd0;
    end else begin
      dout_d = dout_d;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fsm_q       <= S_IDLE;
      mode_q      <= 1'b0;
      kernel_q    <= 25'd0;
      req_cnt_q   <= 10'd0;
      din_ready_q <= 1'b0;
      pix_en_q    <= 1'b0;
      col_q       <= 5'd0;
      row_q       <= 5'd0;
      for (int k = 0; k < 4; k++) begin
        for (int c = 0; c < 28; c++) begin
          lbuf_q[k][c] <= 32'sd0;
        end
      end
      for (int rr = 0; rr < 5; rr++) begin
        for (int cc = 0; cc < 5; cc++) begin
          win_q[rr][cc] <= 32'sd0;
        end
      end
      win_vld_q  <= 1'b0;
      wi_q       <= 5'd0;
      wj_q       <= 5'd0;
      conv_q     <= 32'sd0;
      conv_vld_q <= 1'b0;
      ci_q       <= 5'd0;
      cj_q       <= 5'd0;
      hprev_q    <= 32'sd0;
      for (int h = 0; h < 12; h++) begin
        hbuf_q[h] <= 32'sd0;
      end
      ovalid_q <= 1'b0;
      done_q   <= 1'b0;
      dout_q   <= 32'sd0;
    end else begin
      fsm_q       <= fsm_d;
      mode_q      <= mode_d;
      kernel_q    <= kernel_d;
      req_cnt_q   <= req_cnt_d;
      din_ready_q <= din_ready_d;
      pix_en_q    <= pix_en_d;
      col_q       <= col_d;
      row_q       <= row_d;
      lbuf_q      <= lbuf_d;
      win_q       <= win_d;
      win_vld_q   <= win_vld_d;
      wi_q        <= wi_d;
      wj_q        <= wj_d;
      conv_q      <= conv_d;
      conv_vld_q  <= conv_vld_d;
      ci_q        <= ci_d;
      cj_q        <= cj_d;
      hprev_q     <= hprev_d;
      hbuf_q      <= hbuf_d;
      ovalid_q    <= ovalid_d;
      done_q      <= done_d;
      dout_q      <= dout_d;
    end
  end

  assign din_ready = din_ready_q;
  assign ovalid    = ovalid_q;
  assign done      = done_q;
  assign dout      = dout_q;

endmodule

// File: tb/tb_bnn_conv_mix.sv
// Randomised scoreboard bench for bnn_conv_mix: a direct conv/pool model fills an
// expected queue per run and a negedge monitor pops it whenever ovalid is seen.
module tb_bnn_conv_mix;

  logic               clk = 1'b0;
  logic               rstn;
  logic               start;
  logic               weight_en;
  logic               weight;
  logic               state;
  logic signed [31:0] din;
  logic               din_ready;
  logic               ovalid;
  logic               done;
  logic signed [31:0] dout;

  bnn_conv_mix dut (
    .clk(clk), .rstn(rstn), .start(start), .weight_en(weight_en),
    .weight(weight), .din(din), .state(state), .din_ready(din_ready),
    .ovalid(ovalid), .done(done), .dout(dout)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int img [784];
  bit kb  [25];
  int exp_q [$];
  int exp_total;
  bit mon_en = 1'b0;
  int out_cnt, done_cnt, rdy_cnt;
  int feed_idx;

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Reference: direct 5x5 signed-weight sum per position, then 2x2 max.
  task automatic build_expected(input int w);
    int cv [24][24];
    int acc, m, p;
    exp_q.delete();
    for (int i = 0; i <= w - 5; i++) begin
      for (int j = 0; j <= w - 5; j++) begin
        acc = 0;
        for (int a = 0; a < 5; a++) begin
          for (int b = 0; b < 5; b++) begin
            p = img[(i + a) * w + (j + b)];
            acc = kb[5*a + b] ? acc + p : acc - p;
          end
        end
        cv[i][j] = acc;
      end
    end
    for (int r = 0; r < (w - 4) / 2; r++) begin
      for (int c = 0; c < (w - 4) / 2; c++) begin
        m = cv[2*r][2*c];
        if (cv[2*r][2*c+1]   > m) m = cv[2*r][2*c+1];
        if (cv[2*r+1][2*c]   > m) m = cv[2*r+1][2*c];
        if (cv[2*r+1][2*c+1] > m) m = cv[2*r+1][2*c+1];
        exp_q.push_back(m);
      end
    end
    exp_total = exp_q.size();
  endtask

  // kind 0: constant v, kind 1: ramp w*row+col, kind 2: random
  task automatic fill_img(input int w, input int kind, input int v);
    for (int k = 0; k < w * w; k++) begin
      if (kind == 0)      img[k] = v;
      else if (kind == 1) img[k] = k;
      else                img[k] = int'($urandom);
    end
  endtask

  task automatic set_kernel(input int kind);
    for (int t = 0; t < 25; t++) begin
      if (kind == 0)      kb[t] = 1'b0;
      else if (kind == 1) kb[t] = 1'b1;
      else if (kind == 2) kb[t] = (t == 0);
      else                kb[t] = 1'($urandom);
    end
  endtask

  // Registered pixel source: answers a request seen at an edge just after it.
  initial begin : feeder
    logic rdy;
    din = 32'sd0;
    forever begin
      @(negedge clk);
      rdy = din_ready;
      @(posedge clk);
      #1;
      if (rdy && feed_idx < 784) begin
        din = img[feed_idx];
        feed_idx++;
      end
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (mon_en) begin
      if (din_ready) rdy_cnt++;
      if (done) chk("done_with_ovalid", ovalid, 1);
      if (ovalid) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_ovalid", out_cnt, exp_total);
        end else begin
          chk("dout", dout, exp_q.pop_front());
        end
        if (done) begin
          done_cnt++;
          chk("done_position", out_cnt, exp_total);
        end
      end
    end
  end

  // abort_kind: 0 none, 1 reset, 2 start low; abort_at counts cycles after weight load
  task automatic do_run(input string nm, input bit mode, input bit load,
                        input int pre_bits, input int abort_kind, input int abort_at);
    int w;
    int budget;
    w = mode ? 12 : 28;
    build_expected(w);
    out_cnt  = 0;
    done_cnt = 0;
    rdy_cnt  = 0;
    feed_idx = 0;
    mon_en   = 1'b1;
    state    = mode;
    start    = 1'b1;
    weight_en = load;
    if (load) begin
      for (int t = 0; t < pre_bits + 25; t++) begin
        weight = (t < pre_bits) ? 1'($urandom) : kb[t - pre_bits];
        @(posedge clk);
        #1;
      end
      weight_en = 1'b0;
    end
    budget = 0;
    while (done_cnt == 0 && budget < 3000) begin
      @(posedge clk);
      #1;
      budget++;
      if (abort_kind != 0 && budget == abort_at) break;
    end
    if (abort_kind != 0) begin
      if (abort_kind == 1) begin
        rstn = 1'b0;
        #1;
        chk({nm, "_rst_din_ready"}, din_ready, 0);
        chk({nm, "_rst_ovalid"}, ovalid, 0);
        chk({nm, "_rst_done"}, done, 0);
        chk({nm, "_rst_dout"}, dout, 0);
      end else begin
        start = 1'b0;
        @(posedge clk);
        #1;
        chk({nm, "_abort_din_ready"}, din_ready, 0);
        chk({nm, "_abort_ovalid"}, ovalid, 0);
      end
      mon_en = 1'b0;
      exp_q.delete();
      start  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;
      @(posedge clk);
      #1;
      return;
    end
    chk({nm, "_timeout"}, (budget < 3000) ? 1 : 0, 1);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b0;
    chk({nm, "_ready_cycles"}, rdy_cnt, w * w);
    chk({nm, "_out_count"}, out_cnt, exp_total);
    chk({nm, "_done_count"}, done_cnt, 1);
    chk({nm, "_queue_left"}, exp_q.size(), 0);
  endtask

  initial begin
    rstn      = 1'b0;
    start     = 1'b0;
    weight_en = 1'b0;
    weight    = 1'b0;
    state     = 1'b0;
    feed_idx  = 0;
    #1;
    chk("reset_din_ready", din_ready, 0);
    chk("reset_ovalid", ovalid, 0);
    chk("reset_done", done, 0);
    chk("reset_dout", dout, 0);
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;

    set_kernel(1); fill_img(28, 0, 1);  do_run("uni_pos", 1'b0, 1'b1, 0, 0, 0);
    set_kernel(0); fill_img(28, 0, 1);  do_run("uni_neg", 1'b0, 1'b1, 0, 0, 0);
    set_kernel(1); fill_img(28, 1, 0);  do_run("ramp_m0", 1'b0, 1'b1, 0, 0, 0);
    set_kernel(1); fill_img(12, 1, 0);  do_run("ramp_m1", 1'b1, 1'b1, 0, 0, 0);
    set_kernel(2); fill_img(28, 0, 2);  do_run("single_tap", 1'b0, 1'b1, 3, 0, 0);
    set_kernel(3); fill_img(12, 2, 0);  do_run("rand_m1", 1'b1, 1'b1, 0, 0, 0);
    fill_img(12, 2, 0);                 do_run("reuse_m1", 1'b1, 1'b0, 0, 0, 0);
    set_kernel(3); fill_img(28, 2, 0);  do_run("rand_m0", 1'b0, 1'b1, 2, 0, 0);

    set_kernel(1); fill_img(28, 1, 0);  do_run("ramp_rst", 1'b0, 1'b1, 0, 1, 200);
    fill_img(28, 1, 0);                 do_run("ramp_rerun", 1'b0, 1'b1, 0, 0, 0);
    fill_img(12, 1, 0);                 do_run("reuse_ramp_m1", 1'b1, 1'b0, 0, 0, 0);

    set_kernel(3); fill_img(12, 2, 0);  do_run("start_abort", 1'b1, 1'b1, 0, 2, 60);
    fill_img(12, 2, 0);                 do_run("after_abort", 1'b1, 1'b0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
